// File: rtl/and8_operand_feeder.sv
// Pairs a serial byte stream into {A,B} operands and buffers them in a FIFO for the AND stage.
// Optional delivered-pair counter enabled by defining AND8_FEEDER_PAIR_COUNT_EN.
module and8_operand_feeder #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [7:0]    a_out,
    output logic [7:0]    b_out,
    output logic          pair_valid,
    input  logic          pair_ready,
    output logic [CW-1:0] count,
    output logic          phase,
    output logic [15:0]   pair_total
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        PH_A = 1'b0,
        PH_B = 1'b1
    } phase_e;

    phase_e        phase_q, phase_d;
    logic [7:0]    held_a_q, held_a_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   mem_q [DEPTH];

    logic in_xfer;
    logic push;
    logic pop;

    // in_ready only depends on registered state, never on pair_ready
    always_comb begin
        in_ready   = (phase_q == PH_A) || (count_q != CW'(DEPTH));
        pair_valid = (count_q != '0);
        in_xfer    = in_valid && in_ready && !flush;
        push       = in_xfer && (phase_q == PH_B);
        pop        = pair_valid && pair_ready && !flush;
    end

    always_comb begin
        phase_d  = phase_q;
        held_a_d = held_a_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            phase_d  = PH_A;
            held_a_d = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (in_xfer) begin
                if (phase_q == PH_A) begin
                    held_a_d = in_data;
                    phase_d  = PH_B;
                end else begin
                    phase_d  = PH_A;
                end
            end
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q  <= PH_A;
            held_a_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            phase_q  <= phase_d;
            held_a_q <= held_a_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {held_a_q, in_data};
    end

    always_comb begin
        a_out = '0;
        b_out = '0;
        if (pair_valid) begin
            a_out = mem_q[rd_ptr_q][15:8];
            b_out = mem_q[rd_ptr_q][7:0];
        end
    end

    assign count = count_q;
    assign phase = phase_q;

`ifdef AND8_FEEDER_PAIR_COUNT_EN
    logic [15:0] total_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)    total_q <= '0;
        else if (pop) total_q <= total_q + 16'd1;
    end

    assign pair_total = total_q;
`else
    assign pair_total = '0;
`endif

endmodule

// File: tb/tb_and8_operand_feeder.sv
// Self-checking bench for and8_operand_feeder: directed scenarios plus random traffic against a queue model.
module tb_and8_operand_feeder;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          reset;
    logic          flush;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    a_out;
    logic [7:0]    b_out;
    logic          pair_valid;
    logic          pair_ready;
    logic [CW-1:0] count;
    logic          phase;
    logic [15:0]   pair_total;

    and8_operand_feeder #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_out      (a_out),
        .b_out      (b_out),
        .pair_valid (pair_valid),
        .pair_ready (pair_ready),
        .count      (count),
        .phase      (phase),
        .pair_total (pair_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          passes = 0;
    logic [15:0] mq[$];
    logic        m_phase = 1'b0;
    logic [7:0]  m_held  = 8'h00;
    logic [15:0] m_total = 16'h0000;
    logic        last_accept = 1'b0;
    logic        pr_tog = 1'b0;
    logic [15:0] dut_pops[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic model_ready();
        return !m_phase || (mq.size() != DEPTH);
    endfunction

    task automatic compare_outputs();
        logic v;
        logic [7:0] ea, eb;
        v  = (mq.size() != 0);
        ea = 8'h00;
        eb = 8'h00;
        if (v) begin
            ea = mq[0][15:8];
            eb = mq[0][7:0];
        end
        chk("in_ready",   32'(in_ready),   32'(model_ready()));
        chk("pair_valid", 32'(pair_valid), 32'(v));
        chk("a_out",      32'(a_out),      32'(ea));
        chk("b_out",      32'(b_out),      32'(eb));
        chk("count",      32'(count),      32'(mq.size()));
        chk("phase",      32'(phase),      32'(m_phase));
`ifdef AND8_FEEDER_PAIR_COUNT_EN
        chk("pair_total", 32'(pair_total), 32'(m_total));
`else
        chk("pair_total", 32'(pair_total), 32'h0);
`endif
    endtask

    // One clock: check outputs mid-cycle, then advance the model with the inputs seen at the edge
    task automatic cycle();
        logic rdy, vld;
        #1;
        compare_outputs();
        rdy = model_ready();
        vld = (mq.size() != 0);
        if (pair_valid && pair_ready && !flush) dut_pops.push_back({a_out, b_out});
        @(posedge clk);
        last_accept = in_valid && rdy && !flush;
        if (flush) begin
            mq.delete();
            m_phase = 1'b0;
            m_held  = 8'h00;
        end else begin
            if (vld && pair_ready) begin
                void'(mq.pop_front());
                m_total = m_total + 16'd1;
            end
            if (in_valid && rdy) begin
                if (!m_phase) begin
                    m_held  = in_data;
                    m_phase = 1'b1;
                end else begin
                    mq.push_back({m_held, in_data});
                    m_phase = 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic drive(input logic [7:0] d, input logic v, input logic pr);
        in_data    = d;
        in_valid   = v;
        pair_ready = pr;
        flush      = 1'b0;
        cycle();
    endtask

    task automatic idle(input logic pr);
        drive(8'h00, 1'b0, pr);
    endtask

    task automatic send(input logic [7:0] d, input logic pr, input logic tog);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            if (tog) begin
                drive(d, 1'b1, pr_tog);
                pr_tog = ~pr_tog;
            end else begin
                drive(d, 1'b1, pr);
            end
            ok = last_accept;
        end
        in_valid = 1'b0;
        chk("send_accepted", 32'(ok), 32'h1);
    endtask

    task automatic do_flush(input logic v, input logic pr);
        in_data    = 8'h5A;
        in_valid   = v;
        pair_ready = pr;
        flush      = 1'b1;
        cycle();
        flush = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        pair_ready = 1'b0;
        #3;
        compare_outputs();
        #9;
        reset = 1'b0;

        // Single pair: visible the cycle after the B byte
        send(8'h0C, 1'b0, 1'b0);
        send(8'hF3, 1'b0, 1'b0);
        #1;
        chk("single_valid", 32'(pair_valid), 32'h1);
        chk("single_a",     32'(a_out),      32'h0C);
        chk("single_b",     32'(b_out),      32'hF3);
        chk("single_count", 32'(count),      32'h1);
        idle(1'b0);
        idle(1'b1);

        // Fill to DEPTH, accept a 9th byte, hold off the 10th until a pop
        for (int i = 0; i < 8; i++) send(8'(8'h20 + i), 1'b0, 1'b0);
        send(8'h30, 1'b0, 1'b0);
        #1;
        chk("fill_count", 32'(count),    32'(DEPTH));
        chk("fill_phase", 32'(phase),    32'h1);
        chk("fill_ready", 32'(in_ready), 32'h0);
        drive(8'h31, 1'b1, 1'b0);
        drive(8'h31, 1'b1, 1'b0);
        drive(8'h31, 1'b1, 1'b1);
        drive(8'h31, 1'b1, 1'b0);
        chk("fill_late_accept", 32'(last_accept), 32'h1);
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) idle(1'b1);

        // Concurrent push and pop keeps count
        for (int i = 0; i < 4; i++) send(8'(8'h40 + i), 1'b0, 1'b0);
        send(8'h44, 1'b0, 1'b0);
        send(8'h45, 1'b1, 1'b0);
        chk("conc_count", 32'(count), 32'h2);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Wrap: 10 pairs with pair_ready toggling
        dut_pops.delete();
        pr_tog = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            send(8'(i), 1'b0, 1'b1);
            send(~8'(i), 1'b0, 1'b1);
        end
        for (int i = 0; i < 12; i++) begin
            idle(pr_tog);
            pr_tog = ~pr_tog;
        end
        chk("wrap_pops", 32'(dut_pops.size()), 32'd10);
        for (int i = 0; i < 10 && i < dut_pops.size(); i++)
            chk("wrap_pair", 32'(dut_pops[i]), 32'({8'(i + 1), ~8'(i + 1)}));

        // Flush with live handshakes: held A discarded, FIFO cleared
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        send(8'hAA, 1'b0, 1'b0);
        do_flush(1'b1, 1'b1);
        chk("flush_phase", 32'(phase),      32'h0);
        chk("flush_count", 32'(count),      32'h0);
        chk("flush_valid", 32'(pair_valid), 32'h0);
        idle(1'b1);

        // Asynchronous reset mid-cycle
        send(8'h33, 1'b0, 1'b0);
        send(8'h44, 1'b0, 1'b0);
        send(8'hAA, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        mq.delete();
        m_phase = 1'b0;
        m_held  = 8'h00;
        m_total = 16'h0000;
        compare_outputs();
        #2;
        reset = 1'b0;

        // Delivered-pair counter survives flush
        for (int i = 0; i < 6; i++) send(8'(8'h50 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);
        do_flush(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send(8'(8'h60 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);
`ifdef AND8_FEEDER_PAIR_COUNT_EN
        chk("pair_total_5", 32'(pair_total), 32'd5);
`else
        chk("pair_total_0", 32'(pair_total), 32'd0);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_data    = 8'($urandom);
            pair_ready = 1'($urandom_range(0, 1));
            flush      = ($urandom_range(0, 31) == 0);
            cycle();
        end
        flush = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
